// File: rtl/byte_lane_memory.sv
// byte_lane_memory: single-port RV32 data memory with byte/half/word stores and extended loads
// Ports:
//   i_Clock, i_Reset_n          rising-edge clock, asynchronous active-low reset
//   i_WriteEnable, i_ReadEnable store / load request this cycle
//   i_Address                   byte address
//   i_DataIn                    right-aligned store data
//   i_Mode                      RISC-V funct3 (B, H, W, BU, HU)
//   o_DataOut, o_ReadValid      extended load data, valid the cycle after the load
//   o_MisalignedAccess, o_BadInstruction, o_AccessFault  one-cycle error pulses
// Macro MEMORY_BOUNDS_CHECK_EN enables out-of-range detection on the upper address bits;
// without it those bits are ignored and addresses wrap.
module byte_lane_memory #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 8192,
    parameter     INIT_FILE   = ""
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset_n,
    input  logic                  i_WriteEnable,
    input  logic                  i_ReadEnable,
    input  logic [ADDR_WIDTH-1:0] i_Address,
    input  logic [31:0]           i_DataIn,
    input  logic [2:0]            i_Mode,
    output logic [31:0]           o_DataOut,
    output logic                  o_ReadValid,
    output logic                  o_MisalignedAccess,
    output logic                  o_BadInstruction,
    output logic                  o_AccessFault
);
    localparam int WORD_BITS = $clog2(DEPTH_WORDS);

    logic [3:0][7:0] mem [DEPTH_WORDS];

    logic [WORD_BITS-1:0] idx;
    logic [1:0]           off;
    logic                 req, is_h, is_w, bad, mis, oob;
    logic                 err_bad, err_mis, err_flt, do_write, do_read;
    logic [3:0]           lane_en;
    logic [31:0]          wdata, word_rd, ext;
    logic [7:0]           sel_b;
    logic [15:0]          sel_h;

    assign idx = i_Address[WORD_BITS+1:2];
    assign off = i_Address[1:0];

`ifdef MEMORY_BOUNDS_CHECK_EN
    assign oob = |i_Address[ADDR_WIDTH-1:WORD_BITS+2];
`else
    logic unused_hi;
    assign unused_hi = ^i_Address[ADDR_WIDTH-1:WORD_BITS+2];
    assign oob = 1'b0;
`endif

    always_comb begin
        req      = i_WriteEnable | i_ReadEnable;
        is_h     = i_Mode[1:0] == 2'b01;
        is_w     = i_Mode == 3'b010;
        bad      = i_Mode == 3'b011 || i_Mode[2:1] == 2'b11
                   || (i_WriteEnable && i_Mode[2]) || (i_WriteEnable && i_ReadEnable);
        mis      = (is_h && off[0]) || (is_w && off != 2'b00);
        err_bad  = req && bad;
        err_mis  = req && !bad && mis;
        err_flt  = req && !bad && !mis && oob;
        do_write = i_WriteEnable && !bad && !mis && !oob && i_Reset_n;
        do_read  = i_ReadEnable && !bad && !mis && !oob;
        // store data is replicated across lanes so each lane enable picks its own copy
        lane_en  = is_w ? 4'b1111 : is_h ? (off[1] ? 4'b1100 : 4'b0011) : 4'b0001 << off;
        wdata    = is_w ? i_DataIn : is_h ? {2{i_DataIn[15:0]}} : {4{i_DataIn[7:0]}};
        word_rd  = mem[idx];
        sel_b    = word_rd[8*off +: 8];
        sel_h    = off[1] ? word_rd[31:16] : word_rd[15:0];
        ext      = i_Mode[1:0] == 2'b00 ? {{24{~i_Mode[2] & sel_b[7]}}, sel_b}
                 : i_Mode[1:0] == 2'b01 ? {{16{~i_Mode[2] & sel_h[15]}}, sel_h}
                 : word_rd;
    end

    always_ff @(posedge i_Clock) begin
        for (int b = 0; b < 4; b++)
            if (do_write && lane_en[b]) mem[idx][b] <= wdata[8*b +: 8];
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_DataOut          <= '0;
            o_ReadValid        <= 1'b0;
            o_MisalignedAccess <= 1'b0;
            o_BadInstruction   <= 1'b0;
            o_AccessFault      <= 1'b0;
        end else begin
            o_ReadValid        <= do_read;
            o_MisalignedAccess <= err_mis;
            o_BadInstruction   <= err_bad;
            o_AccessFault      <= err_flt;
            if (do_read) o_DataOut <= ext;
        end
    end
endmodule

// File: tb/tb_byte_lane_memory.sv
// tb_byte_lane_memory: directed self-checking bench for byte_lane_memory
module tb_byte_lane_memory;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0, re = 1'b0;
    logic [31:0] addr = '0, din = '0;
    logic [2:0]  mode = '0;
    logic [31:0] dout;
    logic        valid, mis, bad_i, flt;
    int          total = 0, bad = 0;

    byte_lane_memory dut (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_WriteEnable(we), .i_ReadEnable(re),
        .i_Address(addr), .i_DataIn(din), .i_Mode(mode), .o_DataOut(dout),
        .o_ReadValid(valid), .o_MisalignedAccess(mis), .o_BadInstruction(bad_i),
        .o_AccessFault(flt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // flags packed as {valid, misaligned, bad, fault}
    task automatic chk_out(input string tag, input logic [3:0] f, input logic [31:0] d);
        chk({tag, ".flags"}, {28'd0, valid, mis, bad_i, flt}, {28'd0, f});
        chk({tag, ".data"}, dout, d);
    endtask

    // drive one request at a negedge, return at the next negedge with outputs settled
    task automatic op(input logic w, input logic r, input logic [31:0] a,
                      input logic [31:0] d, input logic [2:0] m);
        we = w; re = r; addr = a; din = d; mode = m;
        @(negedge clk);
        we = 1'b0; re = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        chk_out("reset", 4'b0000, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        // 1. word store / load
        op(1, 0, 32'h10, 32'hDEADBEEF, 3'b010); chk_out("sw10", 4'b0000, 32'h0);
        op(0, 1, 32'h10, 32'h0, 3'b010);        chk_out("lw10", 4'b1000, 32'hDEADBEEF);
        @(negedge clk);                          chk_out("hold", 4'b0000, 32'hDEADBEEF);
        // 2. byte-lane merge and byte extension
        op(1, 0, 32'h20, 32'h11223344, 3'b010);
        op(1, 0, 32'h22, 32'hFFFFFFAA, 3'b000);
        op(0, 1, 32'h20, 32'h0, 3'b010);        chk_out("lw20", 4'b1000, 32'h11AA3344);
        op(0, 1, 32'h22, 32'h0, 3'b000);        chk_out("lb22", 4'b1000, 32'hFFFFFFAA);
        op(0, 1, 32'h22, 32'h0, 3'b100);        chk_out("lbu22", 4'b1000, 32'h000000AA);
        op(0, 1, 32'h23, 32'h0, 3'b000);        chk_out("lb23", 4'b1000, 32'h00000011);
        // 3. halves and misalignment
        op(1, 0, 32'h30, 32'h55667788, 3'b010);
        op(1, 0, 32'h30, 32'h12348001, 3'b001);
        op(0, 1, 32'h30, 32'h0, 3'b010);        chk_out("lw30", 4'b1000, 32'h55668001);
        op(0, 1, 32'h30, 32'h0, 3'b001);        chk_out("lh30", 4'b1000, 32'hFFFF8001);
        op(0, 1, 32'h30, 32'h0, 3'b101);        chk_out("lhu30", 4'b1000, 32'h00008001);
        op(0, 1, 32'h32, 32'h0, 3'b001);        chk_out("lh32", 4'b1000, 32'h00005566);
        op(0, 1, 32'h31, 32'h0, 3'b001);        chk_out("lh31mis", 4'b0100, 32'h00005566);
        op(1, 0, 32'h32, 32'hCAFEF00D, 3'b010); chk_out("sw32mis", 4'b0100, 32'h00005566);
        op(0, 1, 32'h30, 32'h0, 3'b010);        chk_out("lw30b", 4'b1000, 32'h55668001);
        // 4. illegal requests
        op(0, 1, 32'h30, 32'h0, 3'b011);        chk_out("mode011", 4'b0010, 32'h55668001);
        op(0, 1, 32'h31, 32'h0, 3'b111);        chk_out("badprio", 4'b0010, 32'h55668001);
        op(1, 1, 32'h30, 32'h0, 3'b010);        chk_out("rdwr", 4'b0010, 32'h55668001);
        op(1, 0, 32'h30, 32'hFF, 3'b100);       chk_out("sbu", 4'b0010, 32'h55668001);
        op(0, 1, 32'h30, 32'h0, 3'b010);        chk_out("lw30c", 4'b1000, 32'h55668001);
        // back-to-back loads
        we = 0; re = 1; addr = 32'h10; mode = 3'b010;
        @(negedge clk);
        addr = 32'h20;
        chk_out("b2b1", 4'b1000, 32'hDEADBEEF);
        @(negedge clk);
        re = 0;
        chk_out("b2b2", 4'b1000, 32'h11AA3344);
        // 5. reset between request and response
        re = 1; addr = 32'h20; mode = 3'b010;
        #2 rst_n = 1'b0;
        @(negedge clk);
        re = 0;
        chk_out("rstmid", 4'b0000, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        op(0, 1, 32'h20, 32'h0, 3'b010);        chk_out("postrst", 4'b1000, 32'h11AA3344);
        // 6. bounds
        op(1, 0, 32'h0, 32'h01020304, 3'b010);
`ifdef MEMORY_BOUNDS_CHECK_EN
        op(0, 1, 32'h8000, 32'h0, 3'b010);      chk_out("oob", 4'b0001, 32'h11AA3344);
        op(1, 0, 32'h8000, 32'hFFFFFFFF, 3'b010); chk_out("oobw", 4'b0001, 32'h11AA3344);
        op(0, 1, 32'h0, 32'h0, 3'b010);         chk_out("w0", 4'b1000, 32'h01020304);
`else
        op(0, 1, 32'h8000, 32'h0, 3'b010);      chk_out("alias", 4'b1000, 32'h01020304);
        op(0, 1, 32'h8001, 32'h0, 3'b100);      chk_out("aliasb", 4'b1000, 32'h00000003);
`endif
        @(negedge clk);                          chk_out("idle", 4'b0000, dout === 32'h01020304 || dout === 32'h00000003 || dout === 32'h11AA3344 ? dout : 32'hFFFFFFFF);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
